// File: rtl/decade_chain_pkg.sv
// Shared types and helpers for the decade chain counter.
//   state_t     : controller state (idle / carry-borrow ripple)
//   dir_t       : count direction held during a ripple
//   clamp_digit : limits a loaded digit field to base-1
package decade_chain_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RIPPLE = 1'b1
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Any field at or above the radix loads as the largest legal digit.
  function automatic int unsigned clamp_digit(input int unsigned value,
                                              input int unsigned base);
    return (value >= base) ? (base - 1) : value;
  endfunction

endpackage

// File: rtl/decade_digit.sv
// One base-BASE digit of the counter chain.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   step         : advance this digit one position in direction dir
//   dir          : DIR_UP / DIR_DOWN
//   load         : take load_value (clamped to BASE-1); beats step
//   load_value   : raw DIGIT_W-bit field to load
//   value        : registered digit
//   wrap_c       : combinational, this digit would wrap if stepped now
module decade_digit
  import decade_chain_pkg::*;
#(
  parameter int unsigned BASE    = 10,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  dir_t               dir,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_value,
  output logic [DIGIT_W-1:0] value,
  output logic               wrap_c
);

  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(BASE - 1);

  logic [DIGIT_W-1:0] load_clamped;

  assign load_clamped = DIGIT_W'(clamp_digit(32'(load_value), BASE));

  // Wrap is an explicit compare against the radix limits, never binary rollover.
  assign wrap_c = (dir == DIR_UP) ? (value == DIGIT_MAX) : (value == '0);

  // Digit register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_clamped;
    end else if (step) begin
      if (dir == DIR_UP) begin
        value <= wrap_c ? '0 : value + DIGIT_W'(1);
      end else begin
        value <= wrap_c ? DIGIT_MAX : value - DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/decade_chain_counter.sv
// Multi-digit base-BASE up/down counter whose carry/borrow ripples one digit
// per clock, like a dekatron tube chain.
// Optional build macro: DECADE_CHAIN_SATURATE_EN -- when defined, UP at
// all-max or DOWN at all-zero holds the count and pulses overflow instead
// of wrapping.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset (aborts any ripple)
//   up, down    : level increment / decrement requests (both = no-op)
//   load        : parallel load request, highest priority
//   load_value  : value to load, digit 0 in the LSBs
//   count       : current value, one DIGIT_W field per digit
//   busy        : ripple in progress; all commands are dropped
//   zero        : combinational, every digit is 0 (qualify with !busy)
//   overflow    : one-cycle registered pulse on wrap past max/min
module decade_chain_counter
  import decade_chain_pkg::*;
#(
  parameter int unsigned DIGITS  = 3,
  parameter int unsigned BASE    = 10,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      up,
  input  logic                      down,
  input  logic                      load,
  input  logic [DIGITS*DIGIT_W-1:0] load_value,
  output logic [DIGITS*DIGIT_W-1:0] count,
  output logic                      busy,
  output logic                      zero,
  output logic                      overflow
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t             state_q, state_d;
  dir_t               dir_q, dir_d;
  dir_t               dir_step;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               ovf_d;
  logic               load_all;
  logic               wrap_sel;
  logic [DIGITS-1:0]  step;
  logic [DIGITS-1:0]  wrap;
  logic [DIGIT_W-1:0] digit_value [DIGITS];

  // Digit chain.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    decade_digit #(
      .BASE    (BASE),
      .DIGIT_W (DIGIT_W)
    ) u_digit (
      .clk        (clk),
      .rst        (rst),
      .step       (step[g]),
      .dir        (dir_step),
      .load       (load_all),
      .load_value (load_value[g*DIGIT_W +: DIGIT_W]),
      .value      (digit_value[g]),
      .wrap_c     (wrap[g])
    );
    assign count[g*DIGIT_W +: DIGIT_W] = digit_value[g];
  end

  assign zero = (count == '0);
  assign busy = (state_q == ST_RIPPLE);

  // Direction seen by the digits: latched during a ripple, the command in idle.
  assign dir_step = (state_q == ST_RIPPLE) ? dir_q : (down ? DIR_DOWN : DIR_UP);

  // Wrap flag of the digit currently addressed by the ripple index.
  always_comb begin
    wrap_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) wrap_sel = wrap[i];
    end
  end

`ifdef DECADE_CHAIN_SATURATE_EN
  logic all_max;

  // Every digit sits at BASE-1.
  always_comb begin
    all_max = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_value[i] != DIGIT_W'(BASE - 1)) all_max = 1'b0;
    end
  end
`endif

  // Controller state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_UP;
      idx_q    <= '0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      idx_q    <= idx_d;
      overflow <= ovf_d;
    end
  end

  // Next-state, digit steering and overflow decode.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    idx_d    = idx_q;
    ovf_d    = 1'b0;
    step     = '0;
    load_all = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          load_all = 1'b1;
        end else if (up != down) begin
`ifdef DECADE_CHAIN_SATURATE_EN
          if ((up && all_max) || (down && zero)) begin
            ovf_d = 1'b1;
          end else
`endif
          begin
            step[0] = 1'b1;
            if (wrap[0]) begin
              if (DIGITS > 1) begin
                state_d = ST_RIPPLE;
                dir_d   = dir_step;
                idx_d   = IDX_W'(1);
              end else begin
                ovf_d = 1'b1;
              end
            end
          end
        end
      end

      ST_RIPPLE: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) step[i] = 1'b1;
        end
        if (wrap_sel) begin
          if (idx_q == IDX_W'(DIGITS - 1)) begin
            ovf_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/decade_chain_counter.md
Name: decade_chain_counter

Overview:
- Parametrised multi-digit up/down counter of base-BASE digits (default decimal, dekatron style).
- Successor to the single-register up/down counter: one clock, explicit command inputs, parallel load.
- Carry and borrow ripple one digit per clock, mimicking tube-chain propagation, with BUSY and OVERFLOW status.
- Used for the machine's address/data/loop counters feeding the display and sequencer.

Parameters:
- DIGITS, 3: number of digits in the chain (≥1).
- BASE, 10: radix of each digit (2..16).
- DIGIT_W, 4: bits per digit; must satisfy 2**DIGIT_W ≥ BASE.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- UP  in  1  increment request, level, sampled each CLK.
- DOWN  in  1  decrement request, level, sampled each CLK.
- LOAD  in  1  parallel-load request, sampled each CLK.
- LOAD_VALUE  in  DIGITS*DIGIT_W  value to load; digit 0 is the LSBs.
- COUNT  out  DIGITS*DIGIT_W  current value, one digit per DIGIT_W field.
- BUSY  out  1  high while a carry or borrow is rippling; commands are ignored.
- ZERO  out  1  high when every digit is 0.
- OVERFLOW  out  1  one-cycle pulse on wrap past max or min.

Behaviour:
- Interface (decided): one clock CLK. RST is asynchronous and active-low. RST low forces COUNT=0, BUSY=0, OVERFLOW=0, ZERO=1 and state IDLE. This holds at any time, including mid-ripple; a ripple in flight is aborted.
- States:
  - IDLE: commands accepted.
  - RIPPLE: BUSY=1, holds direction DIR and digit index IDX.
- IDLE command priority:
  - LOAD beats UP/DOWN.
  - UP and DOWN together with LOAD low: no change.
  - No command: hold.
- LOAD: COUNT takes LOAD_VALUE at the next edge. Any digit field ≥BASE is clamped to BASE-1. No ripple occurs; latency is 1 cycle.
- UP in IDLE:
  - digit0 < BASE-1: digit0 increments; done in 1 cycle.
  - digit0 = BASE-1: digit0 becomes 0. If DIGITS>1, go to RIPPLE with DIR=up, IDX=1. If DIGITS=1, pulse OVERFLOW.
- DOWN in IDLE: mirror of UP. Digit0=0 becomes BASE-1 and borrows to the next digit.
- RIPPLE, each cycle, digit IDX is updated in direction DIR:
  - No wrap: return to IDLE.
  - Wrap and IDX < DIGITS-1: IDX increments and the state stays RIPPLE.
  - Wrap and IDX = DIGITS-1: OVERFLOW=1 for that single cycle, then IDLE. COUNT ends at all-0 (up) or all-(BASE-1) (down).
- Latency: a carry through k extra digits keeps BUSY high for k cycles. COUNT is valid and final on the first cycle BUSY is low.
- UP, DOWN and LOAD asserted while BUSY=1 are dropped. There is no queueing. Upstream holds a request until it observes BUSY=0.
- ZERO is combinational from the COUNT register. It may glitch high mid-ripple (e.g. 0 digits transiently), so it is qualified by BUSY=0.
- OVERFLOW is registered and low in every cycle except the wrap cycle.
- Digit arithmetic is DIGIT_W wide with explicit compare to BASE-1. There is no binary overflow reliance.

Optional Feature:
- Macro: DECADE_CHAIN_SATURATE_EN.
- Defined:
  - UP when every digit = BASE-1 leaves COUNT unchanged, starts no ripple, and pulses OVERFLOW for one cycle as a limit flag.
  - DOWN when every digit = 0 likewise holds and pulses OVERFLOW.
  - The check is made in IDLE before touching digit0.
- Undefined: wrap-around as above.

Decomposition:
- Package decade_chain_pkg holds:
  - state enum (ST_IDLE, ST_RIPPLE);
  - direction enum (DIR_UP, DIR_DOWN);
  - a function clamping a digit to BASE-1.
- Sub-module decade_digit, one instance per digit:
  - inputs: step enable, direction, load enable, load value;
  - outputs: digit value, wrap flag (combinational: would wrap on this step).
- Top level holds the FSM, IDX and OVERFLOW, and generates the DIGITS instances.

Test Plan (DIGITS=3, BASE=10):
- Reset: RST low mid-operation -> COUNT=000, ZERO=1, BUSY=0, OVERFLOW=0 with no clock edge required.
- Carry ripple: LOAD 099, then one UP pulse:
  - edge1: COUNT=090, BUSY=1;
  - edge2: COUNT=000, BUSY=1 (transient ZERO=1 ignored);
  - edge3: COUNT=100, BUSY=0.
- Wrap: LOAD 999, UP -> 000 after ripple, OVERFLOW high exactly one cycle, ZERO=1. Then DOWN -> 999 with one OVERFLOW pulse.
- Ignored commands: UP held during ripple from 099 -> final 100, not 101. UP+DOWN together at 123 -> stays 123. LOAD+UP at 123 with LOAD_VALUE=456 -> 456.
- Clamp and abort: LOAD_VALUE digits F,C,5 -> COUNT=995. Start ripple from 999 UP, drop RST during BUSY -> 000, BUSY=0 immediately.
- Saturate build (DECADE_CHAIN_SATURATE_EN): 999 UP -> stays 999, OVERFLOW one pulse, BUSY never high. 000 DOWN -> stays 000 with OVERFLOW pulse.
